hall_tick_gen: RTL

- Source end of the tick interface: converts the raw wheel hall-sensor input into a clean single-cycle `tick` pulse that downstream blink/indicator logic consumes.
- Synchronises the asynchronous sensor input, debounces it, and emits `tick` on each confirmed active edge.
- Measures the wheel period in clk cycles between consecutive ticks and flags a stopped wheel on timeout.

---
 rtl/hall_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/hall_tick_gen.sv | 129 ++++++++++++
 3 files changed

// File: rtl/hall_pkg.sv
// Shared types and defaults for the wheel hall-sensor tick path.
// Used by hall_tick_gen; the HALL_REV_COUNT_EN build also uses REV_COUNT_W.
package hall_pkg;

    typedef enum logic [1:0] {
        st_inactive   = 2'd0,
        st_wait_act   = 2'd1,
        st_active     = 2'd2,
        st_wait_inact = 2'd3
    } deb_state_t;

    localparam int DEB_CNT_W = 24;
    localparam int REV_COUNT_W = 16;

    localparam logic [DEB_CNT_W-1:0] DEBOUNCE_CYC_DEF = 24'd500_000;
    localparam logic [31:0] TIMEOUT_CYC_DEF = 32'd300_000_000;

    // Debounce FSM register, kept as one struct so checkers can bind to it.
    typedef struct packed {
        deb_state_t state;
        logic [DEB_CNT_W-1:0] cnt;
    } deb_fsm_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous inputs; both flops reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hall_tick_gen.sv
// Hall sensor front end: synchronise, debounce, emit one tick per active edge, measure period.
// Optional build macro HALL_REV_COUNT_EN adds a wrapping 16-bit rev_count output.
module hall_tick_gen
    import hall_pkg::*;
#(
    parameter logic [DEB_CNT_W-1:0] DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int PERIOD_W = 32,
    parameter logic [PERIOD_W-1:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sensor_in,
    output logic tick,
    output logic level,
    output logic [PERIOD_W-1:0] period,
    output logic period_valid,
    output logic stopped
`ifdef HALL_REV_COUNT_EN
    ,
    output logic [REV_COUNT_W-1:0] rev_count
`endif
);

    localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEBOUNCE_CYC - 24'd1;
    localparam logic [PERIOD_W-1:0] PER_ONE = PERIOD_W'(1);

    logic s;
    deb_fsm_t deb_q;
    logic [PERIOD_W-1:0] per_cnt;

    // Normalise polarity before the synchroniser so reset 0 means "no magnet".
    sync_2ff u_sync (
        .clk(clk),
        .rst(rst),
        .d  (sensor_in ^ ACTIVE_LOW),
        .q  (s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_q.state <= st_inactive;
            deb_q.cnt   <= '0;
            tick        <= 1'b0;
            level       <= 1'b0;
        end else begin
            tick <= 1'b0;
            case (deb_q.state)
                st_inactive: begin
                    if (s) begin
                        deb_q.state <= st_wait_act;
                        deb_q.cnt   <= '0;
                    end
                end
                st_wait_act: begin
                    if (!s) begin
                        deb_q.state <= st_inactive;
                        deb_q.cnt   <= '0;
                    end else if (deb_q.cnt == DEB_LAST) begin
                        deb_q.state <= st_active;
                        deb_q.cnt   <= '0;
                        tick        <= 1'b1;
                        level       <= 1'b1;
                    end else begin
                        deb_q.cnt <= deb_q.cnt + 24'd1;
                    end
                end
                st_active: begin
                    if (!s) begin
                        deb_q.state <= st_wait_inact;
                        deb_q.cnt   <= '0;
                    end
                end
                st_wait_inact: begin
                    if (s) begin
                        deb_q.state <= st_active;
                        deb_q.cnt   <= '0;
                    end else if (deb_q.cnt == DEB_LAST) begin
                        deb_q.state <= st_inactive;
                        deb_q.cnt   <= '0;
                        level       <= 1'b0;
                    end else begin
                        deb_q.cnt <= deb_q.cnt + 24'd1;
                    end
                end
                default: begin
                    deb_q.state <= st_inactive;
                    deb_q.cnt   <= '0;
                    level       <= 1'b0;
                end
            endcase
        end
    end

    // Counter restarts at 1 on the visible tick, so its value at the next tick
    // equals the exact cycle distance between the two pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt      <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            stopped      <= 1'b1;
        end else if (tick) begin
            per_cnt <= PER_ONE;
            if (stopped) begin
                stopped <= 1'b0;
            end else begin
                period       <= per_cnt;
                period_valid <= 1'b1;
            end
        end else if (per_cnt == TIMEOUT_CYC) begin
            stopped      <= 1'b1;
            period_valid <= 1'b0;
        end else begin
            per_cnt <= per_cnt + PER_ONE;
        end
    end

`ifdef HALL_REV_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rev_count <= '0;
        end else if (tick) begin
            rev_count <= rev_count + 16'd1;
        end
    end
`endif

endmodule
